// File: rtl/note_sequencer.sv
// note_sequencer: plays a small table of {tone increment, duration} notes.
//
// Ports:
//   clock, reset           rising-edge clock; asynchronous active-high reset
//   wr_en/wr_addr/wr_inc/wr_dur
//                          note table write port, usable in any state
//   len                    number of notes in the sequence (0..DEPTH)
//   start / stop / loop    begin playback at entry 0 / abort / wrap after last note
//   tone_inc, tone_en      drive the tone generator (inc=0 is a rest)
//   note_idx               table entry being played
//   busy                   high whenever not idle
//   done                   one-cycle pulse at sequence end or on stop
module note_sequencer #(
  parameter int unsigned INC_W    = 6,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 50000,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned LW      = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [INC_W-1:0] wr_inc,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [LW-1:0]    len,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [INC_W-1:0] tone_inc,
  output logic             tone_en,
  output logic [AW-1:0]    note_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Note table storage; deliberately not reset so contents survive a reset.
  logic [INC_W-1:0] inc_mem_q [DEPTH];
  logic [DUR_W-1:0] dur_mem_q [DEPTH];

  state_t           state_q,    state_d;
  logic [AW-1:0]    note_idx_q, note_idx_d;
  logic [INC_W-1:0] tone_inc_q, tone_inc_d;
  logic             tone_en_q,  tone_en_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [PW-1:0]    presc_q,    presc_d;
  logic [DUR_W-1:0] dur_cnt_q,  dur_cnt_d;

  logic             is_last;
  logic [DUR_W-1:0] rd_dur;

  // Table write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      inc_mem_q[wr_addr] <= wr_inc;
      dur_mem_q[wr_addr] <= wr_dur;
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      note_idx_q <= '0;
      tone_inc_q <= '0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      dur_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      tone_inc_q <= tone_inc_d;
      tone_en_q  <= tone_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      dur_cnt_q  <= dur_cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    tone_inc_d = tone_inc_q;
    presc_d    = presc_q;
    dur_cnt_d  = dur_cnt_q;
    done_d     = 1'b0;

    // Compared in LW bits so a live len shrink (or len=0) still ends cleanly.
    is_last = ({1'b0, note_idx_q} + LW'(1)) >= len;
    rd_dur  = dur_mem_q[note_idx_q];

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_d    = S_LOAD;
              note_idx_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          tone_inc_d = inc_mem_q[note_idx_q];
          dur_cnt_d  = rd_dur;
          presc_d    = '0;
          state_d    = (rd_dur != '0) ? S_PLAY : S_GAP;
        end
        S_PLAY: begin
          // One duration tick per full prescaler sweep.
          if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            dur_cnt_d = dur_cnt_q - DUR_W'(1);
            if (dur_cnt_q == DUR_W'(1)) begin
              state_d = S_GAP;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_GAP: begin
          if (is_last) begin
            if (loop && (len != '0)) begin
              state_d    = S_LOAD;
              note_idx_d = '0;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d    = S_LOAD;
            note_idx_d = note_idx_q + AW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    tone_en_d = (state_d == S_PLAY) && (tone_inc_d != '0);
    busy_d    = (state_d != S_IDLE);
  end

  assign tone_inc = tone_inc_q;
  assign tone_en  = tone_en_q;
  assign note_idx = note_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a note-level reference model.
module tb_note_sequencer;

  localparam int unsigned INC_W    = 6;
  localparam int unsigned DUR_W    = 8;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned AW       = 4;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_GAP  = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [INC_W-1:0] wr_inc;
  logic [DUR_W-1:0] wr_dur;
  logic [AW:0]      len;
  logic             start;
  logic             stop;
  logic             loop;
  logic [INC_W-1:0] tone_inc;
  logic             tone_en;
  logic [AW-1:0]    note_idx;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode, current entry, latched increment, play cycles left.
  int m_mode, m_idx, m_inc, m_left, m_done;
  int m_tab_inc [DEPTH];
  int m_tab_dur [DEPTH];

  // Observation counters for directed scenarios
  int cnt_en, cnt_done, cnt_busy;

  note_sequencer #(
    .INC_W(INC_W), .DUR_W(DUR_W), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_inc(wr_inc), .wr_dur(wr_dur),
    .len(len), .start(start), .stop(stop), .loop(loop),
    .tone_inc(tone_inc), .tone_en(tone_en), .note_idx(note_idx),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_inc = 0; m_left = 0; m_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_update();
    int nd;
    nd = 0;
    if (stop && m_mode != M_IDLE) begin
      m_mode = M_IDLE;
      nd = 1;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          if (len != 0) begin m_mode = M_LOAD; m_idx = 0; end
          else nd = 1;
        end
        M_LOAD: begin
          m_inc = m_tab_inc[m_idx];
          if (m_tab_dur[m_idx] > 0) begin
            m_mode = M_PLAY;
            m_left = m_tab_dur[m_idx] * TICK_DIV;
          end else begin
            m_mode = M_GAP;
          end
        end
        M_PLAY: begin
          m_left--;
          if (m_left == 0) m_mode = M_GAP;
        end
        default: begin
          if (m_idx + 1 >= int'(len)) begin
            if (loop && len != 0) begin m_mode = M_LOAD; m_idx = 0; end
            else begin m_mode = M_IDLE; nd = 1; end
          end else begin
            m_mode = M_LOAD;
            m_idx++;
          end
        end
      endcase
    end
    m_done = nd;
    if (wr_en) begin
      m_tab_inc[wr_addr] = int'(wr_inc);
      m_tab_dur[wr_addr] = int'(wr_dur);
    end
  endtask

  task automatic check_outputs();
    check_val("busy",     int'(busy),     int'(m_mode != M_IDLE));
    check_val("tone_en",  int'(tone_en),  int'(m_mode == M_PLAY && m_inc != 0));
    check_val("tone_inc", int'(tone_inc), m_inc);
    check_val("note_idx", int'(note_idx), m_idx);
    check_val("done",     int'(done),     m_done);
  endtask

  // One clock: inputs already driven; update model at the edge, check at negedge.
  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_outputs();
    cnt_en   += int'(tone_en);
    cnt_done += int'(done);
    cnt_busy += int'(busy);
  endtask

  task automatic write_entry(input int a, input int inc, input int dur);
    wr_en = 1'b1; wr_addr = AW'(a); wr_inc = INC_W'(inc); wr_dur = DUR_W'(dur);
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_en = 0; cnt_done = 0; cnt_busy = 0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_inc = '0; wr_dur = '0;
    len = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin m_tab_inc[i] = 0; m_tab_dur[i] = 0; end
    model_reset();
    clear_counts();

    // Reset state
    @(negedge clock);
    check_outputs();
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) write_entry(i, 0, 0);

    // Two-note sequence, no loop
    write_entry(0, 5, 2);
    write_entry(1, 9, 1);
    len = 5'd2; loop = 1'b0;
    clear_counts();
    pulse_start();
    repeat (19) step();
    check_val("seq_en_cycles", cnt_en, 12);
    check_val("seq_done_pulses", cnt_done, 1);
    check_val("seq_idle", int'(busy), 0);

    // Loop back to entry 0, then stop in PLAY
    loop = 1'b1;
    pulse_start();
    repeat (21) step();
    check_val("loop_idx", int'(note_idx), 0);
    check_val("loop_inc", int'(tone_inc), 5);
    check_val("loop_playing", int'(tone_en), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_val("stop_en", int'(tone_en), 0);
    check_val("stop_done", int'(done), 1);
    check_val("stop_busy", int'(busy), 0);
    step();
    check_val("stop_done_once", int'(done), 0);

    // Rest note and zero-duration note
    write_entry(0, 0, 3);
    write_entry(1, 7, 0);
    loop = 1'b0;
    clear_counts();
    pulse_start();
    repeat (19) step();
    check_val("rest_en_cycles", cnt_en, 0);
    check_val("rest_busy_cycles", cnt_busy, 16);
    check_val("rest_done", cnt_done, 1);

    // Empty sequence
    len = '0;
    clear_counts();
    pulse_start();
    check_val("len0_busy", int'(busy), 0);
    check_val("len0_done", int'(done), 1);
    step();
    check_val("len0_done_once", int'(done), 0);

    // Stop in IDLE does nothing; start+stop in IDLE starts
    stop = 1'b1;
    step();
    check_val("idle_stop_done", int'(done), 0);
    write_entry(0, 5, 2);
    write_entry(1, 9, 1);
    len = 5'd2; loop = 1'b1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_val("start_stop_busy", int'(busy), 1);

    // Async reset mid-PLAY of entry 1
    repeat (13) step();
    check_val("pre_reset_idx", int'(note_idx), 1);
    #2 reset = 1'b1;
    #1;
    check_val("areset_tone_en", int'(tone_en), 0);
    check_val("areset_busy", int'(busy), 0);
    check_val("areset_idx", int'(note_idx), 0);
    check_val("areset_done", int'(done), 0);
    model_reset();
    @(negedge clock);
    check_outputs();
    reset = 1'b0;
    check_val("table_kept", m_tab_inc[0], 5);

    // Rewrite the playing entry: current note unchanged, new value next pass
    pulse_start();
    repeat (3) step();
    write_entry(0, 12, 2);
    repeat (4) step();
    check_val("rewrite_cur", int'(tone_inc), 5);
    repeat (9) step();
    check_val("rewrite_next", int'(tone_inc), 12);
    check_val("rewrite_next_en", int'(tone_en), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Random traffic
    len = 5'd4;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) len = (AW+1)'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 99) == 0) loop = ~loop;
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_inc  = ($urandom_range(0, 3) == 0) ? '0 : INC_W'($urandom_range(1, 63));
      wr_dur  = DUR_W'($urandom_range(0, 3));
      step();
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter INC_W, default 6, meaning the tone increment width (matches the tone generator phase step).
REQ-002 The block SHALL have parameter DUR_W, default 8, meaning the per-note duration width in ticks.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the number of note table entries (power of two).
REQ-004 The block SHALL have parameter TICK_DIV, default 50000, meaning the number of clocks per duration tick (>=2).
REQ-005 The block SHALL have the following ports, one per line as name, direction, width, meaning.
  clock     in   1       single clock, rising edge.
  reset     in   1       asynchronous, active-high.
  wr_en     in   1       write note table entry this cycle.
  wr_addr   in   log2(DEPTH)  table address.
  wr_inc    in   INC_W   tone increment to store.
  wr_dur    in   DUR_W   duration (ticks) to store.
  len       in   log2(DEPTH)+1  notes in sequence, 0..DEPTH.
  start     in   1       begin playback from entry 0.
  stop      in   1       abort playback.
  loop      in   1       restart at entry 0 after last note.
  tone_inc  out  INC_W   increment to tone generator.
  tone_en   out  1       tone generator enable.
  note_idx  out  log2(DEPTH)  entry being played.
  busy      out  1       high in any state except IDLE.
  done      out  1       one-cycle pulse at sequence end or stop.

Function
REQ-006 The note table SHALL be written synchronously when wr_en is high, in any state; a write to the entry currently playing SHALL take effect only at that entry's next LOAD.
REQ-007 The FSM SHALL have states IDLE, LOAD, PLAY, GAP; busy = (state != IDLE).
REQ-008 IDLE: start=1 and len>0 -> LOAD with note_idx=0; start=1 and len=0 -> stay IDLE and pulse done the next cycle.
REQ-009 LOAD (exactly 1 cycle): latch table[note_idx] into tone_inc and a duration counter; clear the tick prescaler; go to PLAY if dur>0, else to GAP.
REQ-010 PLAY: tone_en=1 iff tone_inc!=0 (inc=0 encodes a rest); the prescaler counts 0..TICK_DIV-1 and wraps; on each wrap the duration counter decrements; when it goes 1->0 the FSM goes to GAP.
REQ-011 PLAY latency: a note of dur D SHALL hold tone_en for exactly D*TICK_DIV cycles.
REQ-012 GAP (exactly 1 cycle, tone_en=0): if note_idx==len-1 then go to LOAD with note_idx=0 when loop=1, else go to IDLE and pulse done; otherwise go to LOAD with note_idx+1.
REQ-013 stop=1 in LOAD, PLAY or GAP SHALL go to IDLE on the next edge, force tone_en=0, and pulse done once; stop has priority over every other transition.
REQ-014 stop=1 in IDLE SHALL have no effect and no done pulse.
REQ-015 start=1 while busy SHALL be ignored; start and stop together in IDLE SHALL start playback.
REQ-016 len, loop SHALL be sampled live in GAP; if len changes mid-sequence such that note_idx>=len-1, the sequence ends at that GAP.
REQ-017 tone_en SHALL be 0 in IDLE, LOAD and GAP; tone_inc SHALL hold its last loaded value in IDLE.
REQ-018 All outputs SHALL be registered; the prescaler SHALL be ceil(log2(TICK_DIV)) bits wide, with no overflow beyond TICK_DIV-1.

Reset
REQ-019 reset=1 SHALL immediately force state=IDLE, tone_inc=0, tone_en=0, note_idx=0, busy=0, done=0, prescaler=0, duration counter=0, independent of clock.
REQ-020 Table contents SHALL NOT be reset; a reset in mid-play SHALL abort playback without a done pulse.

Verification (TICK_DIV=4)
REQ-021 Write {inc=5,dur=2},{inc=9,dur=1}, len=2, pulse start -> tone_inc=5, tone_en high 8 cycles, GAP 1, tone_inc=9 high 4 cycles, then done pulses once and busy=0.
REQ-022 Same table, loop=1 -> after entry 1, note_idx returns to 0 with tone_inc=5; stop in PLAY -> tone_en=0 and done=1 next cycle, then IDLE.
REQ-023 Entry {inc=0,dur=3} -> busy high, tone_en stays 0 for 12 cycles; entry {inc=7,dur=0} -> LOAD then GAP directly, no tone_en.
REQ-024 len=0, start -> busy stays 0, and done pulses once one cycle later.
REQ-025 Assert reset asynchronously mid-PLAY (between edges) -> tone_en, busy, note_idx all 0 before the next edge; no done pulse; then start replays from entry 0.
REQ-026 Rewrite the playing entry during PLAY -> the current note is unchanged, and the new value is used on the next loop pass.
